// File: rtl/ddr_rd_bridge.sv
// ddr_rd_bridge: turns (byte address, beat count) read requests into AXI4
// INCR read bursts. A burst never crosses a 4 KB page and is never longer than
// 256 beats. The number of bursts in flight is capped, and read data goes back
// to the top in order through a two-entry skid buffer.
module ddr_rd_bridge #(
   parameter int DDR_W           = 512,
   parameter int DDR_ADDR_W      = 32,
   parameter int BURST_W         = 16,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DDR_ADDR_W-1:0] req_addr,
   input  logic [BURST_W-1:0]    req_size,
   input  logic                  req_valid,
   output logic                  req_ready,
   output logic [DDR_ADDR_W-1:0] m_araddr,
   output logic [7:0]            m_arlen,
   output logic                  m_arvalid,
   input  logic                  m_arready,
   input  logic [DDR_W-1:0]      m_rdata,
   input  logic [1:0]            m_rresp,
   input  logic                  m_rlast,
   input  logic                  m_rvalid,
   output logic                  m_rready,
   output logic [DDR_W-1:0]      out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  rd_err
);
   localparam int BEAT_B = DDR_W / 8;
   localparam int OFF_W  = $clog2(BEAT_B);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t                state_q, state_d;
   logic [DDR_ADDR_W-1:0] cur_addr_q, cur_addr_d;
   logic [BURST_W-1:0]    remain_q, remain_d;
   logic [3:0]            outst_q, outst_d;
   logic [12:0]           to4k;
   logic [31:0]           beats4k, lim, n;
   logic                  ar_hs, r_hs, rlast_hs, pop;
   logic [DDR_W-1:0]      buf_q [2];
   logic                  wptr_q, rptr_q, rready_q, err_q;
   logic [1:0]            occ_q, occ_d;

   assign ar_hs    = m_arvalid & m_arready;
   assign r_hs     = m_rvalid & m_rready;
   assign rlast_hs = r_hs & m_rlast;
   assign pop      = out_valid & out_ready;

   // Size of the next burst: the smallest of the beats left, the beats left
   // before the 4 KB page ends, and 256
   always_comb begin
      to4k    = 13'h1000 - {1'b0, cur_addr_q[11:0]};
      beats4k = 32'(to4k >> OFF_W);
      lim     = (beats4k < 32'd256) ? beats4k : 32'd256;
      n       = (32'(remain_q) < lim) ? 32'(remain_q) : lim;
   end

   // cur_addr/remain change only on an AR handshake, so AR addr/len hold steady.
   // While arvalid is high the count can only fall, so arvalid stays high until
   // arready.
   assign m_arvalid = (state_q == ISSUE) &&
                      ((outst_q < 4'(MAX_OUTSTANDING)) || rlast_hs);
   assign m_araddr  = (state_q == ISSUE) ? cur_addr_q : '0;
   assign m_arlen   = (state_q == ISSUE) ? 8'(n - 32'd1) : 8'd0;
   assign req_ready = (state_q == IDLE);

   // Next state: accept a request in IDLE, step through its bursts in ISSUE
   always_comb begin
      state_d    = state_q;
      cur_addr_d = cur_addr_q;
      remain_d   = remain_q;
      case (state_q)
         IDLE: begin
            if (req_valid && (req_size != '0)) begin
               cur_addr_d = req_addr & ~DDR_ADDR_W'(BEAT_B - 1);
               remain_d   = req_size;
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
            if (ar_hs) begin
               cur_addr_d = cur_addr_q + DDR_ADDR_W'(n << OFF_W);
               remain_d   = remain_q - BURST_W'(n);
               if (remain_d == '0) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Request and burst-walk registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cur_addr_q <= '0;
         remain_q   <= '0;
      end else begin
         state_q    <= state_d;
         cur_addr_q <= cur_addr_d;
         remain_q   <= remain_d;
      end
   end

   // Bursts in flight. A stray rlast with nothing in flight leaves the count at 0.
   always_comb begin
      outst_d = outst_q;
      if (ar_hs && !rlast_hs)
         outst_d = outst_q + 4'd1;
      else if (rlast_hs && !ar_hs && (outst_q != 4'd0))
         outst_d = outst_q - 4'd1;
   end

   // Outstanding burst counter register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) outst_q <= 4'd0;
      else      outst_q <= outst_d;
   end

   // Skid buffer occupancy after this cycle's push and pop
   always_comb begin
      occ_d = occ_q + {1'b0, r_hs} - {1'b0, pop};
   end

   // Two-entry skid buffer. rready is registered, and the spare entry takes the
   // beat that arrives in the cycle after the head stalls.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         buf_q[0] <= '0;
         buf_q[1] <= '0;
         wptr_q   <= 1'b0;
         rptr_q   <= 1'b0;
         occ_q    <= 2'd0;
         rready_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         if (r_hs) begin
            buf_q[wptr_q] <= m_rdata;
            wptr_q        <= ~wptr_q;
         end
         if (pop) rptr_q <= ~rptr_q;
         occ_q    <= occ_d;
         rready_q <= (occ_d != 2'd2);
         if (r_hs && (m_rresp != 2'b00)) err_q <= 1'b1;
      end
   end

   assign m_rready  = rready_q;
   assign out_valid = (occ_q != 2'd0);
   assign out_data  = buf_q[rptr_q];
   assign rd_err    = err_q;

endmodule

// File: doc/ddr_rd_bridge.md
Name: ddr_rd_bridge

Overview:
- Sits between the AXI4 memory interconnect and one DDR read channel of fpga_cnn_train_top (one instance per channel: ddr1_in, ddr2_in).
- Accepts the top's read requests (byte address + beat count) and splits each into legal AXI4 INCR read bursts:
  - never crossing a 4 KB boundary;
  - never exceeding 256 beats.
- Limits outstanding bursts and returns read data to the top in order, through a full-throughput skid buffer.

Parameters:
- DDR_W, 512, data width in bits; one beat = DDR_W/8 bytes.
- DDR_ADDR_W, 32, byte-address width.
- BURST_W, 16, width of the request beat count.
- MAX_OUTSTANDING, 4, maximum AR bursts issued without a completed rlast (1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- req_addr  in  DDR_ADDR_W  request start byte address; low log2(DDR_W/8) bits ignored (treated 0).
- req_size  in  BURST_W  request length in beats.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when valid&ready.
- m_araddr  out  DDR_ADDR_W  AXI AR address.
- m_arlen  out  8  AXI AR length minus 1.
- m_arvalid  out  1  AXI AR valid.
- m_arready  in  1  AXI AR ready.
- m_rdata  in  DDR_W  AXI R data.
- m_rresp  in  2  AXI R response.
- m_rlast  in  1  AXI R last.
- m_rvalid  in  1  AXI R valid.
- m_rready  out  1  AXI R ready.
- out_data  out  DDR_W  data to top (ddrX_in_data).
- out_valid  out  1  data valid.
- out_ready  in  1  top ready.
- rd_err  out  1  sticky: any beat received with rresp != OKAY.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE; req_ready=1; m_arvalid=0; m_araddr=0; m_arlen=0; m_rready=0; out_valid=0; out_data=0; rd_err=0; outstanding count=0.
  - Reset mid-operation drops all state. The interconnect must be reset at the same time.
- FSM states: IDLE, ISSUE.
  - IDLE: req_ready=1. On req_valid handshake:
    - size==0: request consumed; no AR issued; stay IDLE.
    - otherwise: register cur_addr=req_addr (aligned) and remain=req_size; go to ISSUE. req_ready=0 from the next cycle.
  - ISSUE: burst length computation:
    - beats_to_4k = (4096 - cur_addr[11:0]) / (DDR_W/8);
    - n = min(remain, beats_to_4k, 256);
    - m_arlen = n-1, m_araddr = cur_addr.
  - ISSUE: m_arvalid behaviour:
    - asserted when outstanding < MAX_OUTSTANDING, or when an rlast handshake occurs in the same cycle;
    - once asserted, araddr/arlen are held stable and arvalid stays high until m_arready (AXI rule).
  - ISSUE: on AR handshake: cur_addr += n*(DDR_W/8); remain -= n; outstanding += 1. If remain becomes 0, go to IDLE (req_ready=1 next cycle); otherwise stay in ISSUE and issue the next burst from the next cycle.
- AR latency: the first m_arvalid appears exactly 1 cycle after request acceptance, when below the outstanding limit.
- Outstanding counter:
  - +1 on AR handshake; -1 on R handshake with m_rlast.
  - Both in the same cycle: count unchanged.
  - Never exceeds MAX_OUTSTANDING; never underflows (an rlast with count 0 is a protocol error; count saturates at 0).
- R path: 2-entry skid buffer.
  - m_rready = buffer not full (registered).
  - out_valid/out_data come from the buffer head.
  - Full throughput: 1 beat/cycle when out_ready is held high.
  - Beats are delivered in arrival order; no loss or duplication under any out_ready pattern.
  - out_valid/out_data are held stable while out_valid & !out_ready.
- Simultaneous buffer push and pop: occupancy unchanged.
- rd_err: set on any R handshake with m_rresp != 2'b00. Cleared only by reset. Data is still forwarded.
- Bridge does not track request/beat matching; the top counts beats itself.

Test Plan (DDR_W=512, i.e. 64 B beats, MAX_OUTSTANDING=4 unless noted):
1. req 0x1000 size 16, arready=1, out_ready=1 → one AR: araddr 0x1000, arlen 15, 1 cycle after accept; 16 beats out in order; req_ready=1 the cycle after the AR handshake.
2. 4 KB crossing: req 0x0F80 size 8 → AR 0x0F80 arlen 1, then AR 0x1000 arlen 5; 8 beats out.
3. Long request: req 0x0 size 200 → ARs 0x0/63, 0x1000/63, 0x2000/63, 0x3000/7.
4. Outstanding limit, MAX_OUTSTANDING=2, size 200, R withheld → exactly 2 ARs, arvalid then held high. After first rlast, the third AR handshakes in the same or next cycle.
5. Backpressure: 64-beat burst with an incrementing-data pattern, out_ready random 50% → output sequence identical to input; m_rready drops only when the buffer is full; no beats lost.
6. Edge cases:
   - size 0 → accepted, no AR.
   - rresp=2'b10 on beat 3 → rd_err=1 from the next cycle, data still delivered.
   - rst low mid-burst → all outputs at reset values asynchronously, rd_err=0.
